hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NRD, default 2, meaning number of ID-stage register read ports (1..4).
REQ-002 SHALL have parameter LAT_ALU, default 0, meaning stall cycles a consumer waits behind an ALU producer (0 = full forwarding).
REQ-003 SHALL have parameter LAT_LOAD, default 1, meaning stall cycles a consumer waits behind a load producer (max 7).
REQ-004 SHALL have ports, clock and reset first; reset is synchronous and active-high:
  CLK  in  1  clock, rising edge
  RST  in  1  reset, synchronous, active-high
  id_valid  in  1  ID holds a real instruction
  id_rsel  in  NRD*5  packed source register numbers, port i at [5i+4:5i]
  id_ren  in  NRD  per-port source-used flag
  id_wsel  in  5  destination register of ID instruction
  id_regWEN  in  1  ID instruction writes a register
  id_isload  in  1  ID instruction is a load
  id_redirect  in  1  branch taken or jump resolved in ID
  mem_dmemREN, mem_dmemWEN  in  1 each  MEM-stage data access
  dhit  in  1  data memory acknowledge
  pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register enables
  ifid_flush, idex_flush  out  1 each  insert bubble into stage register
  hazard  out  1  any stall, flush or freeze this cycle
  state  out  2  FSM state (RUN=0, DSTALL=1, FREEZE=2, FLUSH=3)

Function
REQ-005 SHALL keep one pending counter per register 1..31, width ceil(log2(max(LAT_ALU,LAT_LOAD)+1)); register 0 never pending.
REQ-006 SHALL define freeze = (mem_dmemREN | mem_dmemWEN) & ~dhit.
REQ-007 SHALL define dstall = ~freeze & id_valid & any port i with id_ren[i], rsel_i != 0, counter[rsel_i] != 0.
REQ-008 SHALL define issue = id_valid & ~dstall & ~freeze & id_regWEN & id_wsel != 0.
REQ-009 SHALL, each cycle freeze is low, decrement every nonzero counter by 1; on issue, load counter[id_wsel] with LAT_LOAD if id_isload else LAT_ALU; load wins over decrement on the same register.
REQ-010 SHALL hold all counters unchanged while freeze is high.
REQ-011 SHALL, during freeze, drive all five enables low and both flushes low; state = FREEZE.
REQ-012 SHALL, during dstall, drive pc_en=0, ifid_en=0, idex_flush=1, idex_en/exmem_en/memwb_en=1; state = DSTALL.
REQ-013 SHALL, when id_redirect & id_valid & ~dstall & ~freeze, drive ifid_flush=1, all enables high; state = FLUSH; id_redirect SHALL be ignored during dstall or freeze.
REQ-014 SHALL otherwise drive all enables high, flushes low; state = RUN.
REQ-015 SHALL apply priority FREEZE > DSTALL > FLUSH > RUN; all outputs combinational from current inputs and registered counters (zero-cycle latency).
REQ-016 SHALL assert hazard whenever state != RUN.
REQ-017 SHALL let a new issue to a register already pending overwrite its counter (youngest producer wins).

Reset
REQ-018 SHALL, on CLK edge with RST=1, clear all counters (and statistics counters if built); takes priority over freeze and issue.
REQ-019 SHALL, while RST=1, drive state=RUN, all enables high, flushes low, hazard=0, regardless of other inputs.
REQ-020 SHALL, after reset mid-stall, resume with no pending registers; first instruction after reset never stalls.

Configuration
REQ-021 SHALL, with HAZARD_STATS_EN defined, add outputs stall_cnt, flush_cnt, freeze_cnt (32 bits each), incremented once per cycle in DSTALL, FLUSH, FREEZE respectively, saturating at 0xFFFFFFFF, cleared by RST.
REQ-022 SHALL, without HAZARD_STATS_EN, omit those ports and registers entirely; all other behaviour identical.

Verification
REQ-023 Load-use: LAT_LOAD=1, issue lw $8 then consumer rsel0=8 next cycle -> exactly 1 cycle DSTALL (pc_en=0, idex_flush=1), then RUN.
REQ-024 Freeze mid-stall: counter[8]=1, mem_dmemREN=1, dhit=0 for 3 cycles -> state FREEZE 3 cycles, counter[8] stays 1, then 1 DSTALL cycle once dhit=1.
REQ-025 Register 0 and overwrite: issue lw $0 then consumer of $0 -> no stall; issue lw $9 then ALU write $9 (LAT_ALU=0) -> consumer of $9 next cycle sees no stall.
REQ-026 Redirect: id_redirect=1 in RUN -> ifid_flush=1 one cycle; id_redirect=1 during DSTALL -> ifid_flush=0 until stall clears.
REQ-027 Reset: RST=1 while counter[5]=1 and freeze high -> next cycle state=RUN, consumer of $5 not stalled; with HAZARD_STATS_EN, all counts read 0.
REQ-028 Parameters: NRD=3, LAT_ALU=2 -> ALU producer to port-2 consumer stalls exactly 2 cycles.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: register-scoreboard hazard unit for a 5-stage pipeline.
// Each architectural register 1..31 has a small down-counter holding the
// number of stall cycles a consumer must still wait behind its producer.
// The stage-control outputs are decoded combinationally every cycle.
// Optional build macro: HAZARD_STATS_EN adds 32-bit saturating stall/flush/
// freeze occupancy counters.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   RUN    | normal flow, all stage registers advance
//   DSTALL | data hazard in ID: hold PC and IF/ID, bubble into ID/EX
//   FREEZE | data memory not acknowledged: hold the whole pipeline
//   FLUSH  | redirect resolved in ID: squash the fetched instruction
module hazard_scoreboard #(
    parameter int NRD      = 2,
    parameter int LAT_ALU  = 0,
    parameter int LAT_LOAD = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             id_valid,
    input  logic [NRD*5-1:0] id_rsel,
    input  logic [NRD-1:0]   id_ren,
    input  logic [4:0]       id_wsel,
    input  logic             id_regWEN,
    input  logic             id_isload,
    input  logic             id_redirect,
    input  logic             mem_dmemREN,
    input  logic             mem_dmemWEN,
    input  logic             dhit,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             hazard,
    output logic [1:0]       state
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt,
    output logic [31:0]      freeze_cnt
`endif
);

    localparam int MAXLAT = (LAT_ALU > LAT_LOAD) ? LAT_ALU : LAT_LOAD;
    // Keep at least one bit so full forwarding (all latencies 0) still elaborates.
    localparam int CW = (MAXLAT < 1) ? 1 : $clog2(MAXLAT + 1);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] VAL_ALU = CW'(LAT_ALU);
    localparam logic [CW-1:0] VAL_LD  = CW'(LAT_LOAD);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DSTALL = 2'd1,
        FREEZE = 2'd2,
        FLUSH  = 2'd3
    } hz_state_t;

    hz_state_t       cur_st;
    logic [CW-1:0]   pend [1:31];
    logic [31:0]     busy;
    logic            freeze;
    logic            dstall;
    logic            issue;
    logic [CW-1:0]   issue_val;
    logic [4:0]      rs;

    // Busy vector; register 0 is hardwired never-pending.
    always_comb begin
        busy = '0;
        for (int i = 1; i < 32; i++) begin
            busy[i] = (pend[i] != '0);
        end
    end

    // Hazard conditions from current ID/MEM inputs and registered counters.
    always_comb begin
        freeze = (mem_dmemREN | mem_dmemWEN) & ~dhit;
        dstall = 1'b0;
        rs     = '0;
        for (int i = 0; i < NRD; i++) begin
            rs = id_rsel[5*i +: 5];
            if (id_ren[i] && (rs != 5'd0) && busy[rs]) begin
                dstall = 1'b1;
            end
        end
        dstall    = dstall & id_valid & ~freeze;
        issue     = id_valid & ~dstall & ~freeze & id_regWEN & (id_wsel != 5'd0);
        issue_val = id_isload ? VAL_LD : VAL_ALU;
    end

    // Stage-control decode, priority FREEZE > DSTALL > FLUSH > RUN; reset forces RUN.
    always_comb begin
        cur_st     = RUN;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!RST) begin
            if (freeze) begin
                cur_st   = FREEZE;
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end else if (dstall) begin
                cur_st     = DSTALL;
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else if (id_redirect && id_valid) begin
                cur_st     = FLUSH;
                ifid_flush = 1'b1;
            end
        end
        state  = cur_st;
        hazard = (cur_st != RUN);
    end

    // Pending counters: youngest issue overwrites, otherwise count down; frozen while memory waits.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 1; i < 32; i++) pend[i] <= '0;
        end else if (!freeze) begin
            for (int i = 1; i < 32; i++) begin
                if (issue && (id_wsel == i[4:0])) begin
                    pend[i] <= issue_val;
                end else if (pend[i] != '0) begin
                    pend[i] <= pend[i] - ONE;
                end
            end
        end
    end

`ifdef HAZARD_STATS_EN
    // Saturating per-state occupancy counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (cur_st == DSTALL && stall_cnt  != '1) stall_cnt  <= stall_cnt  + 32'd1;
            if (cur_st == FLUSH  && flush_cnt  != '1) flush_cnt  <= flush_cnt  + 32'd1;
            if (cur_st == FREEZE && freeze_cnt != '1) freeze_cnt <= freeze_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: instance a uses default parameters,
// instance b uses NRD=3, LAT_ALU=2. Outputs are packed into a 10-bit word
// {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, hazard, state}.
module tb_hazard_scoreboard;

    localparam logic [9:0] E_RUN = 10'b11111_00_0_00;
    localparam logic [9:0] E_DST = 10'b00111_01_1_01;
    localparam logic [9:0] E_FRZ = 10'b00000_00_1_10;
    localparam logic [9:0] E_FLS = 10'b11111_10_1_11;

    logic CLK = 1'b0;
    logic RST;
    int   tests  = 0;
    int   failed = 0;

    always #5 CLK = ~CLK;

    // instance a signals
    logic       a_valid, a_wen, a_ld, a_redir, a_mrd, a_mwr, a_hit;
    logic [9:0] a_rsel;
    logic [1:0] a_ren;
    logic [4:0] a_wsel;
    logic       a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_ifl, a_idfl, a_hz;
    logic [1:0] a_st;
    logic [9:0] a_obs;

    // instance b signals
    logic        b_valid, b_wen, b_ld, b_redir, b_mrd, b_mwr, b_hit;
    logic [14:0] b_rsel;
    logic [2:0]  b_ren;
    logic [4:0]  b_wsel;
    logic        b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_ifl, b_idfl, b_hz;
    logic [1:0]  b_st;
    logic [9:0]  b_obs;

    assign a_obs = {a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_ifl, a_idfl, a_hz, a_st};
    assign b_obs = {b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_ifl, b_idfl, b_hz, b_st};

    hazard_scoreboard u_a (
        .CLK(CLK), .RST(RST),
        .id_valid(a_valid), .id_rsel(a_rsel), .id_ren(a_ren), .id_wsel(a_wsel),
        .id_regWEN(a_wen), .id_isload(a_ld), .id_redirect(a_redir),
        .mem_dmemREN(a_mrd), .mem_dmemWEN(a_mwr), .dhit(a_hit),
        .pc_en(a_pc), .ifid_en(a_ifid), .idex_en(a_idex), .exmem_en(a_exmem),
        .memwb_en(a_memwb), .ifid_flush(a_ifl), .idex_flush(a_idfl),
        .hazard(a_hz), .state(a_st)
    );

    hazard_scoreboard #(.NRD(3), .LAT_ALU(2), .LAT_LOAD(1)) u_b (
        .CLK(CLK), .RST(RST),
        .id_valid(b_valid), .id_rsel(b_rsel), .id_ren(b_ren), .id_wsel(b_wsel),
        .id_regWEN(b_wen), .id_isload(b_ld), .id_redirect(b_redir),
        .mem_dmemREN(b_mrd), .mem_dmemWEN(b_mwr), .dhit(b_hit),
        .pc_en(b_pc), .ifid_en(b_ifid), .idex_en(b_idex), .exmem_en(b_exmem),
        .memwb_en(b_memwb), .ifid_flush(b_ifl), .idex_flush(b_idfl),
        .hazard(b_hz), .state(b_st)
    );

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Drive instance a: valid, rs0, rs1, ren, wsel, wen, isload, redirect, mem read, dhit.
    task automatic drv_a(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [1:0] ren, input logic [4:0] ws, input logic wen,
                         input logic ld, input logic redir, input logic mrd, input logic hit);
        a_valid = v;   a_rsel = {r1, r0}; a_ren = ren; a_wsel = ws;
        a_wen   = wen; a_ld   = ld;       a_redir = redir;
        a_mrd   = mrd; a_mwr  = 1'b0;     a_hit = hit;
    endtask

    // Drive instance b: valid, rs0, rs1, rs2, ren, wsel, wen, isload.
    task automatic drv_b(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [2:0] ren, input logic [4:0] ws,
                         input logic wen, input logic ld);
        b_valid = v;   b_rsel = {r2, r1, r0}; b_ren = ren; b_wsel = ws;
        b_wen   = wen; b_ld   = ld;           b_redir = 1'b0;
        b_mrd   = 1'b0; b_mwr = 1'b0;         b_hit = 1'b0;
    endtask

    // Check combinational outputs mid-cycle, then commit on the next rising edge.
    task automatic cyc_a(input string tag, input logic [9:0] exp);
        #2;
        chk(tag, a_obs, exp);
        @(posedge CLK);
        #1;
    endtask

    task automatic cyc_b(input string tag, input logic [9:0] exp);
        #2;
        chk(tag, b_obs, exp);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        drv_a(1, 5'd3, 5'd4, 2'b11, 5'd3, 1, 1, 1, 1, 0);
        drv_b(0, 0, 0, 0, 3'b000, 0, 0, 0);
        @(posedge CLK);
        #1;
        cyc_a("reset_forces_run", E_RUN);
        RST = 1'b0;

        // load-use, one stall cycle
        drv_a(1, 0, 0, 2'b00, 5'd8, 1, 1, 0, 0, 1);  cyc_a("lw8_issue", E_RUN);
        drv_a(1, 5'd8, 0, 2'b01, 0, 0, 0, 0, 0, 1);  cyc_a("loaduse_stall", E_DST);
        cyc_a("loaduse_release", E_RUN);

        // freeze holds counter, then one stall
        drv_a(1, 0, 0, 2'b00, 5'd8, 1, 1, 0, 0, 1);  cyc_a("lw8_issue2", E_RUN);
        drv_a(1, 5'd8, 0, 2'b01, 0, 0, 0, 0, 1, 0);
        cyc_a("freeze_1", E_FRZ);
        cyc_a("freeze_2", E_FRZ);
        cyc_a("freeze_3", E_FRZ);
        drv_a(1, 5'd8, 0, 2'b01, 0, 0, 0, 0, 1, 1);  cyc_a("post_freeze_stall", E_DST);
        drv_a(1, 5'd8, 0, 2'b01, 0, 0, 0, 0, 0, 1);  cyc_a("post_freeze_run", E_RUN);

        // register 0 never pending
        drv_a(1, 0, 0, 2'b00, 5'd0, 1, 1, 0, 0, 1);  cyc_a("lw0_issue", E_RUN);
        drv_a(1, 0, 5'd0, 2'b10, 0, 0, 0, 0, 0, 1);  cyc_a("r0_no_stall", E_RUN);

        // ALU write overwrites pending load
        drv_a(1, 0, 0, 2'b00, 5'd9, 1, 1, 0, 0, 1);  cyc_a("lw9_issue", E_RUN);
        drv_a(1, 0, 0, 2'b00, 5'd9, 1, 0, 0, 0, 1);  cyc_a("alu9_overwrite", E_RUN);
        drv_a(1, 0, 5'd9, 2'b10, 0, 0, 0, 0, 0, 1);  cyc_a("r9_no_stall", E_RUN);

        // port 1 stalls; disabled port does not
        drv_a(1, 0, 0, 2'b00, 5'd10, 1, 1, 0, 0, 1); cyc_a("lw10_issue", E_RUN);
        drv_a(1, 0, 5'd10, 2'b10, 0, 0, 0, 0, 0, 1); cyc_a("port1_stall", E_DST);
        cyc_a("port1_release", E_RUN);
        drv_a(1, 0, 0, 2'b00, 5'd11, 1, 1, 0, 0, 1); cyc_a("lw11_issue", E_RUN);
        drv_a(1, 5'd11, 0, 2'b00, 0, 0, 0, 0, 0, 1); cyc_a("ren_off_no_stall", E_RUN);

        // redirect
        drv_a(1, 0, 0, 2'b00, 0, 0, 0, 1, 0, 1);     cyc_a("redirect_flush", E_FLS);
        drv_a(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 1);     cyc_a("redirect_invalid", E_RUN);
        drv_a(1, 0, 0, 2'b00, 5'd12, 1, 1, 0, 0, 1); cyc_a("lw12_issue", E_RUN);
        drv_a(1, 5'd12, 0, 2'b01, 0, 0, 0, 1, 0, 1); cyc_a("redirect_in_stall", E_DST);
        cyc_a("redirect_after_stall", E_FLS);
        drv_a(1, 0, 0, 2'b00, 0, 0, 0, 1, 1, 0);     cyc_a("redirect_in_freeze", E_FRZ);

        // no issue while frozen
        drv_a(1, 0, 0, 2'b00, 5'd13, 1, 1, 0, 1, 0); cyc_a("lw13_frozen", E_FRZ);
        drv_a(1, 5'd13, 0, 2'b01, 0, 0, 0, 0, 0, 1); cyc_a("r13_not_issued", E_RUN);

        // reset mid-hazard clears scoreboard
        drv_a(1, 0, 0, 2'b00, 5'd5, 1, 1, 0, 0, 1);  cyc_a("lw5_issue", E_RUN);
        RST = 1'b1;
        drv_a(1, 5'd5, 0, 2'b01, 0, 0, 0, 1, 1, 0);  cyc_a("reset_over_freeze", E_RUN);
        RST = 1'b0;
        drv_a(1, 5'd5, 0, 2'b01, 0, 0, 0, 0, 0, 1);  cyc_a("after_reset_no_stall", E_RUN);
        drv_a(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);

        // instance b: NRD=3, LAT_ALU=2
        drv_b(1, 0, 0, 0, 3'b000, 5'd7, 1, 0);       cyc_b("b_alu7_issue", E_RUN);
        drv_b(1, 0, 0, 5'd7, 3'b100, 0, 0, 0);       cyc_b("b_port2_stall1", E_DST);
        cyc_b("b_port2_stall2", E_DST);
        cyc_b("b_port2_release", E_RUN);
        drv_b(1, 0, 0, 0, 3'b000, 5'd3, 1, 1);       cyc_b("b_lw3_issue", E_RUN);
        drv_b(1, 0, 0, 5'd3, 3'b100, 0, 0, 0);       cyc_b("b_loaduse_stall", E_DST);
        cyc_b("b_loaduse_release", E_RUN);
        drv_b(1, 0, 0, 0, 3'b000, 5'd4, 1, 1);       cyc_b("b_lw4_issue", E_RUN);
        drv_b(1, 0, 0, 0, 3'b000, 5'd4, 1, 0);       cyc_b("b_alu4_overwrite", E_RUN);
        drv_b(1, 5'd4, 0, 0, 3'b001, 0, 0, 0);       cyc_b("b_young_stall1", E_DST);
        cyc_b("b_young_stall2", E_DST);
        cyc_b("b_young_release", E_RUN);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded 20000 time units");
        $fatal(1, "timeout");
    end

endmodule
